int_to_fp_encoder: RTL and testbench
====================================

Name: int_to_fp_encoder

Overview:
Sequential converter that takes a signed 32-bit two's-complement integer and produces an operand in the team's 32-bit floating-point format. The format is sign[31], exponent[30:25] (6 bits, biased), fraction[24:0] with a hidden leading 1. The block is the operand-producing (encoding) side of the floating-point adder datapath. It feeds op_A_in/op_B_in and reports status with the adder's status coding. Normalization is done iteratively, one left shift per clock.

Parameters:
BIAS, 31, exponent bias; encoded exponent = BIAS + bit index of the leading 1; legal range 0..62.

Ports:
clock_100kHz  in   1   clock
reset         in   1   asynchronous, active-low reset
start         in   1   request conversion of int_in; sampled only in IDLE
int_in        in   32  signed two's-complement integer
busy          out  1   high while a conversion is in progress (state != IDLE)
done          out  1   one-cycle pulse; data_out/status_out valid from this cycle
data_out      out  32  encoded float; holds until the next done
status_out    out  4   0 exact, 1 overflow, 2 underflow, 3 inexact
state_dbg     out  2   current state encoding: 0 IDLE, 1 NORMALIZE, 2 PACK

Behaviour:
- Reset (async, reset=0):
  - State IDLE.
  - busy=0, done=0, data_out=0, status_out=0, state_dbg=0.
  - Internal mag/exp/sign/zero registers cleared.
  - Reset mid-conversion aborts it; no done is produced.
- IDLE:
  - busy=0.
  - On a clock edge with start=1:
    - sign <= int_in[31].
    - mag <= |int_in| as 32-bit unsigned; 0x80000000 maps to 0x80000000.
    - exp <= BIAS+31, held in a 7-bit internal register.
    - If int_in==0: zero <= 1, go to PACK. Otherwise go to NORMALIZE.
- NORMALIZE:
  - If mag[31]=1: go to PACK.
  - Otherwise: mag <= mag<<1 and exp <= exp-1, stay in NORMALIZE.
  - Takes lz+1 cycles, where lz is the leading-zero count of |int_in|.
- PACK, one cycle, registered at its edge:
  - Zero input: data_out=0x00000000, status_out=0.
  - Else if exp>=63: data_out={sign,6'd63,25'd0}, status_out=1.
  - Else if exp==0: data_out={sign,31'd0}, status_out=2.
  - Else: data_out={sign,exp[5:0],mag[30:6]}. status_out=3 if mag[5:0]!=0 (truncated bits lost), else 0.
  - done <= 1, zero <= 0, next state IDLE.
- done returns to 0 on the following edge.
- Latency:
  - Non-zero input: done is high in the cycle after edge k+lz+2, where k is the edge that samples start.
  - Zero input: done is high after edge k+1.
  - Minimum new-start spacing: a start is accepted on the edge right after done rises (state is IDLE then).
- start while busy: ignored, no queuing. int_in is only sampled in IDLE.
- With default BIAS=31, exp ranges 31..62, so status 1 and 2 never occur. They are reachable only with non-default BIAS.
- Rounding: truncation toward zero magnitude, which matches the adder.

Optional Feature:
ROUND_NEAREST_EN
- Defined:
  - PACK rounds to nearest-even using lsb=mag[6], round=mag[5], sticky=|mag[4:0].
  - Increment the fraction when round & (sticky | lsb).
  - A fraction carry-out sets fraction=0 and exp=exp+1, re-checked against the overflow rule (exp>=63 gives status 1).
  - status_out=3 whenever mag[5:0]!=0.
  - Latency is unchanged.
- Undefined: pure truncation as above.

Test Plan:
- int_in=1, start pulse → done after 34 edges (lz=31), data_out=0x3E000000, status_out=0.
- int_in=5 → data_out=0x42800000, status 0; int_in=-5 (0xFFFFFFFB) → data_out=0xC2800000, status 0.
- int_in=0 → done after 2 edges, data_out=0x00000000, status 0; int_in=0x80000000 → data_out=0xFC000000, status 0, done after 3 edges.
- int_in=0x7FFFFFFF → data_out=0x7BFFFFFF, status 3. With ROUND_NEAREST_EN: data_out=0x7C000000, status 3 (mantissa carry bumps exponent).
- Start pulsed again during NORMALIZE with a different int_in → ignored, first result delivered unchanged. Reset asserted mid-NORMALIZE → all outputs 0, no done, next start converts normally.
- BIAS=40 build, int_in=0x40000000 → exponent 70 ≥ 63 → data_out=0x7E000000, status 1. BIAS=0 build, int_in=1 → data_out=0x00000000, status 2.

Source files
------------

// File: rtl/int_to_fp_encoder.sv
// int_to_fp_encoder
//   Converts a signed 32-bit two's-complement integer into the 32-bit float
//   operand format used by the adder datapath:
//     sign[31], exponent[30:25] (6-bit, biased), fraction[24:0] (hidden 1).
//   Normalization is iterative: one left shift per clock until mag[31] is set.
//   Optional build macro ROUND_NEAREST_EN selects round-to-nearest-even in
//   PACK. When it is undefined, PACK truncates.
//
// Parameters
//   BIAS         exponent bias (encoded exp = BIAS + index of leading 1)
// Ports
//   clock_100kHz clock
//   reset        async active-low reset
//   start        conversion request, sampled only in IDLE
//   int_in       signed integer input
//   busy         high whenever state != IDLE
//   done         one-cycle pulse; data_out/status_out valid from this cycle
//   data_out     encoded float, held until the next done
//   status_out   0 exact, 1 overflow, 2 underflow, 3 inexact
//   state_dbg    0 IDLE, 1 NORMALIZE, 2 PACK
module int_to_fp_encoder #(
  parameter int BIAS = 31
) (
  input  logic        clock_100kHz,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] int_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] data_out,
  output logic [3:0]  status_out,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, NORMALIZE = 2'd1, PACK = 2'd2} state_t;

  localparam logic [6:0] EXP_INIT = 7'(BIAS + 31);

  state_t      state;
  logic [31:0] mag;
  logic [6:0]  exp_q;
  logic        sign_q;
  logic        zero_q;

  // |int_in|; 0x80000000 negates to itself, which is the correct magnitude
  logic [31:0] abs_in;
  assign abs_in = int_in[31] ? (~int_in + 32'd1) : int_in;

  // PACK-stage fraction and exponent (after optional rounding). The exponent
  // is widened to 8 bits so a rounding carry cannot wrap it.
  logic [24:0] frac;
  logic [7:0]  exp_r;
`ifdef ROUND_NEAREST_EN
  logic        rnd_inc;
  logic [25:0] frac_sum;
  assign rnd_inc  = mag[5] & ((|mag[4:0]) | mag[6]);
  assign frac_sum = {1'b0, mag[30:6]} + {25'd0, rnd_inc};
  // on carry-out frac_sum[24:0] is already zero
  assign frac     = frac_sum[24:0];
  assign exp_r    = {1'b0, exp_q} + {7'd0, frac_sum[25]};
`else
  assign frac     = mag[30:6];
  assign exp_r    = {1'b0, exp_q};
`endif

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clock_100kHz or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mag        <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      zero_q     <= 1'b0;
      done       <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sign_q <= int_in[31];
            mag    <= abs_in;
            exp_q  <= EXP_INIT;
            if (int_in == 32'd0) begin
              zero_q <= 1'b1;
              state  <= PACK;
            end else begin
              state  <= NORMALIZE;
            end
          end
        end
        NORMALIZE: begin
          if (mag[31]) begin
            state <= PACK;
          end else begin
            mag   <= mag << 1;
            exp_q <= exp_q - 7'd1;
          end
        end
        PACK: begin
          if (zero_q) begin
            data_out   <= 32'd0;
            status_out <= 4'd0;
          end else if (exp_r >= 8'd63) begin
            data_out   <= {sign_q, 6'd63, 25'd0};
            status_out <= 4'd1;
          end else if (exp_r == 8'd0) begin
            data_out   <= {sign_q, 31'd0};
            status_out <= 4'd2;
          end else begin
            data_out   <= {sign_q, exp_r[5:0], frac};
            status_out <= (|mag[5:0]) ? 4'd3 : 4'd0;
          end
          done   <= 1'b1;
          zero_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_to_fp_encoder.sv
// Directed bench for int_to_fp_encoder. Three instances share stimulus:
// the default BIAS=31 build plus BIAS=40 and BIAS=0 builds for the
// overflow/underflow paths.
module tb_int_to_fp_encoder;

  logic        clock_100kHz = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] int_in;

  logic        busy, done;
  logic [31:0] data_out;
  logic [3:0]  status_out;
  logic [1:0]  state_dbg;

  logic        busy_40, done_40;
  logic [31:0] data_40;
  logic [3:0]  status_40;
  logic [1:0]  state_40;

  logic        busy_0, done_0;
  logic [31:0] data_0;
  logic [3:0]  status_0;
  logic [1:0]  state_0;

  int total = 0;
  int bad   = 0;
  int lat;
  int done_seen;

  always #5 clock_100kHz = ~clock_100kHz;

  int_to_fp_encoder u_dut (
    .clock_100kHz(clock_100kHz), .reset(reset), .start(start), .int_in(int_in),
    .busy(busy), .done(done), .data_out(data_out), .status_out(status_out),
    .state_dbg(state_dbg));

  int_to_fp_encoder #(.BIAS(40)) u_b40 (
    .clock_100kHz(clock_100kHz), .reset(reset), .start(start), .int_in(int_in),
    .busy(busy_40), .done(done_40), .data_out(data_40), .status_out(status_40),
    .state_dbg(state_40));

  int_to_fp_encoder #(.BIAS(0)) u_b0 (
    .clock_100kHz(clock_100kHz), .reset(reset), .start(start), .int_in(int_in),
    .busy(busy_0), .done(done_0), .data_out(data_0), .status_out(status_0),
    .state_dbg(state_0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a start pulse; returns just after the sampling edge.
  task automatic kick(input logic [31:0] v);
    @(negedge clock_100kHz);
    int_in = v;
    start  = 1'b1;
    @(posedge clock_100kHz);
    #1;
    start  = 1'b0;
  endtask

  // Count edges (start edge included) until done; bounded.
  task automatic wait_done(output int n);
    n = 1;
    while (done !== 1'b1 && n < 100) begin
      @(posedge clock_100kHz);
      #1;
      n++;
    end
  endtask

  task automatic conv(input string tag, input logic [31:0] v, input int exp_lat,
                      input logic [31:0] exp_data, input logic [3:0] exp_st);
    int n;
    kick(v);
    wait_done(n);
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_data"}, data_out, exp_data);
    check({tag, "_st"}, 32'(status_out), 32'(exp_st));
    @(posedge clock_100kHz);
    #1;
    check({tag, "_done_drop"}, 32'(done), 32'd0);
    check({tag, "_hold"}, data_out, exp_data);
  endtask

  initial begin
    reset  = 1'b0;
    start  = 1'b0;
    int_in = 32'd0;
    repeat (2) @(posedge clock_100kHz);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_st", 32'(status_out), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    @(negedge clock_100kHz);
    reset = 1'b1;

    conv("one", 32'd1, 34, 32'h3E000000, 4'd0);
    conv("pos5", 32'd5, 32, 32'h42800000, 4'd0);
    conv("neg5", 32'hFFFFFFFB, 32, 32'hC2800000, 4'd0);
    conv("zero", 32'd0, 2, 32'h00000000, 4'd0);
    conv("minint", 32'h80000000, 3, 32'hFC000000, 4'd0);
`ifdef ROUND_NEAREST_EN
    conv("maxint", 32'h7FFFFFFF, 4, 32'h7C000000, 4'd3);
`else
    conv("maxint", 32'h7FFFFFFF, 4, 32'h7BFFFFFF, 4'd3);
`endif

    // BIAS=40 overflow; default build gives exp 61 exactly
    conv("b31_2p30", 32'h40000000, 4, 32'h7A000000, 4'd0);
    check("b40_data", data_40, 32'h7E000000);
    check("b40_st", 32'(status_40), 32'd1);

    // BIAS=0 underflow
    conv("b31_one", 32'd1, 34, 32'h3E000000, 4'd0);
    check("b0_data", data_0, 32'h00000000);
    check("b0_st", 32'(status_0), 32'd2);

    // start during NORMALIZE is ignored
    kick(32'd1);
    repeat (3) @(posedge clock_100kHz);
    #1;
    check("busy_mid", 32'(busy), 32'd1);
    check("state_mid", 32'(state_dbg), 32'd1);
    kick(32'd5);
    wait_done(lat);
    check("ign_lat", 32'(lat), 32'd30);   // 34 total minus 4 edges already spent
    check("ign_data", data_out, 32'h3E000000);

    // back-to-back: start accepted on the edge right after done rises
    kick(32'h80000000);
    wait_done(lat);
    check("b2b_a_lat", 32'(lat), 32'd3);
    conv("b2b_b", 32'd0, 2, 32'h00000000, 4'd0);

    // reset mid-NORMALIZE aborts with no done
    kick(32'd1);
    repeat (4) @(posedge clock_100kHz);
    @(negedge clock_100kHz);
    reset = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_state", 32'(state_dbg), 32'd0);
    check("arst_data", data_out, 32'd0);
    check("arst_st", 32'(status_out), 32'd0);
    @(negedge clock_100kHz);
    reset = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock_100kHz);
      #1;
      if (done === 1'b1) done_seen++;
    end
    check("arst_no_done", 32'(done_seen), 32'd0);
    conv("post_rst", 32'd5, 32, 32'h42800000, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
